// File: rtl/serial_adc_ctrl_if.sv
// ---------------------------------------------------------------------------
// | Module  : serial_adc_ctrl_if                                            |
// | Brief   : CPU command / converter serial signals of serial_adc_ctrl      |
// | Rev     : 1.0  initial release                                          |
// ---------------------------------------------------------------------------
`default_nettype none

interface serial_adc_ctrl_if;
  // CPU and converter inputs to the controller
  logic start;
  logic sdata;
  logic cs_n;
  logic rd_n;
  // controller outputs
  logic conv;
  logic dsc;
  logic take;
  logic int_n;
  logic busy;
  logic overrun;

  // CPU/converter side
  modport master (
    output start, sdata, cs_n, rd_n,
    input  conv, dsc, take, int_n, busy, overrun
  );

  // controller side
  modport slave (
    input  start, sdata, cs_n, rd_n,
    output conv, dsc, take, int_n, busy, overrun
  );
endinterface

`default_nettype wire

// File: rtl/serial_adc_ctrl.sv
// ---------------------------------------------------------------------------
// | Module  : serial_adc_ctrl                                               |
// | Brief   : Sequencer for an 8-bit serial-output A/D converter: convert   |
// |           pulse, serial clock/shift window, parallel capture, CPU       |
// |           interrupt and tri-stated result port                         |
// | Rev     : 1.0  initial release                                          |
// ---------------------------------------------------------------------------
`default_nettype none

module serial_adc_ctrl #(
  parameter int NBITS       = 8,
  parameter int CLK_DIV     = 4,
  parameter int CONV_CYCLES = 16
) (
  input  wire              clk,
  input  wire              rst_n,
  serial_adc_ctrl_if.slave bus,
  // the result pin is electrically tri-stated, so it stays a plain net port
  output tri   [NBITS-1:0] data
);

  localparam int PH_W   = (2 * CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
  localparam int CONV_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam int BIT_W  = (NBITS > 1) ? $clog2(NBITS) : 1;

  localparam logic [PH_W-1:0]   c_PH_LAST   = PH_W'(2 * CLK_DIV - 1);
  localparam logic [PH_W-1:0]   c_PH_HIGH   = PH_W'(CLK_DIV);
  localparam logic [CONV_W-1:0] c_CONV_LAST = CONV_W'(CONV_CYCLES - 1);
  localparam logic [BIT_W-1:0]  c_BIT_LAST  = BIT_W'(NBITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CONV  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CONV_W-1:0]  r_conv_cnt;
  logic [CONV_W-1:0]  w_conv_cnt_nxt;
  logic [PH_W-1:0]    r_ph;
  logic [PH_W-1:0]    w_ph_nxt;
  logic [PH_W-1:0]    w_ph_inc;
  logic [BIT_W-1:0]   r_bit;
  logic [BIT_W-1:0]   w_bit_nxt;
  logic [NBITS-1:0]   r_shift;
  logic [NBITS-1:0]   w_shift_nxt;
  logic [NBITS-1:0]   r_result;
  logic [NBITS-1:0]   w_result_nxt;
  logic               r_conv;
  logic               w_conv_nxt;
  logic               r_dsc;
  logic               w_dsc_nxt;
  logic               r_take;
  logic               w_take_nxt;
  logic               r_busy;
  logic               w_busy_nxt;
  logic               r_int_n;
  logic               w_int_n_nxt;
  logic               r_overrun;
  logic               w_overrun_nxt;
  logic               w_read;

  // a read is any edge that sees the port selected and strobed
  assign w_read   = ~bus.cs_n & ~bus.rd_n;
  assign w_ph_inc = r_ph + PH_W'(1);

  assign bus.conv    = r_conv;
  assign bus.dsc     = r_dsc;
  assign bus.take    = r_take;
  assign bus.busy    = r_busy;
  assign bus.int_n   = r_int_n;
  assign bus.overrun = r_overrun;

  // result port drives only while selected and strobed, floats otherwise
  assign data = w_read ? r_result : {NBITS{1'bz}};

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // counters, shift path and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conv_cnt <= '0;
      r_ph       <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_result   <= '0;
      r_conv     <= 1'b0;
      r_dsc      <= 1'b0;
      r_take     <= 1'b0;
      r_busy     <= 1'b0;
      r_int_n    <= 1'b1;
      r_overrun  <= 1'b0;
    end else begin
      r_conv_cnt <= w_conv_cnt_nxt;
      r_ph       <= w_ph_nxt;
      r_bit      <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
      r_result   <= w_result_nxt;
      r_conv     <= w_conv_nxt;
      r_dsc      <= w_dsc_nxt;
      r_take     <= w_take_nxt;
      r_busy     <= w_busy_nxt;
      r_int_n    <= w_int_n_nxt;
      r_overrun  <= w_overrun_nxt;
    end
  end

  // next-state and next-output decode; DONE overrides a same-edge read
  always_comb begin
    w_state_nxt    = r_state;
    w_conv_cnt_nxt = r_conv_cnt;
    w_ph_nxt       = r_ph;
    w_bit_nxt      = r_bit;
    w_shift_nxt    = r_shift;
    w_result_nxt   = r_result;
    w_conv_nxt     = r_conv;
    w_dsc_nxt      = r_dsc;
    w_take_nxt     = r_take;
    w_busy_nxt     = r_busy;
    w_int_n_nxt    = r_int_n;
    w_overrun_nxt  = r_overrun;

    if (w_read) begin
      w_int_n_nxt   = 1'b1;
      w_overrun_nxt = 1'b0;
    end

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt    = S_CONV;
          w_conv_cnt_nxt = '0;
          w_conv_nxt     = 1'b1;
          w_busy_nxt     = 1'b1;
        end
      end

      S_CONV: begin
        if (r_conv_cnt == c_CONV_LAST) begin
          w_state_nxt = S_SHIFT;
          w_conv_nxt  = 1'b0;
          w_take_nxt  = 1'b1;
          w_dsc_nxt   = 1'b0;
          w_ph_nxt    = '0;
          w_bit_nxt   = '0;
        end else begin
          w_conv_cnt_nxt = r_conv_cnt + CONV_W'(1);
        end
      end

      S_SHIFT: begin
        if (r_ph == c_PH_LAST) begin
          // end of a bit's high phase: next bit or finish
          w_ph_nxt  = '0;
          w_dsc_nxt = 1'b0;
          if (r_bit == c_BIT_LAST) begin
            w_state_nxt = S_DONE;
            w_take_nxt  = 1'b0;
            w_bit_nxt   = '0;
          end else begin
            w_bit_nxt = r_bit + BIT_W'(1);
          end
        end else begin
          w_ph_nxt  = w_ph_inc;
          w_dsc_nxt = (w_ph_inc >= c_PH_HIGH);
          // sample on the edge that raises dsc; first bit ends in the MSB
          if (w_ph_inc == c_PH_HIGH) begin
            w_shift_nxt = {r_shift[NBITS-2:0], bus.sdata};
          end
        end
      end

      S_DONE: begin
        w_state_nxt  = S_IDLE;
        w_result_nxt = r_shift;
        w_busy_nxt   = 1'b0;
        w_int_n_nxt  = 1'b0;
        if (!r_int_n) begin
          w_overrun_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_adc_ctrl.sv
// ---------------------------------------------------------------------------
// | Module  : tb_serial_adc_ctrl                                            |
// | Brief   : Self-checking bench for serial_adc_ctrl: timing model compared |
// |           every cycle plus directed literal expectations                |
// | Rev     : 1.0  initial release                                          |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_serial_adc_ctrl;

  localparam int NB        = 8;
  localparam int CD        = 4;
  localparam int CC        = 16;
  localparam int SHIFT_LEN = 2 * CD * NB;     // 64
  localparam int TOT       = CC + SHIFT_LEN + 1; // 81: edge of result/int_n

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_adc_ctrl_if bus ();
  serial_adc_ctrl_if bus_f ();

  wire [NB-1:0] data_bus;
  wire [NB-1:0] data_f;

  // released result port reads as all ones
  for (genvar gi = 0; gi < NB; gi++) begin : g_pull
    pullup (data_bus[gi]);
    pullup (data_f[gi]);
  end

  serial_adc_ctrl #(.NBITS(NB), .CLK_DIV(CD), .CONV_CYCLES(CC)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .data  (data_bus)
  );

  serial_adc_ctrl #(.NBITS(NB), .CLK_DIV(1), .CONV_CYCLES(1)) u_dut_fast (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_f),
    .data  (data_f)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- behavioural model ----------------
  int          m_cyc    = 0;
  int          m_e0     = 0;
  bit          m_active = 1'b0;
  logic [NB-1:0] m_shift  = '0;
  logic [NB-1:0] m_result = '0;
  bit          m_int_n  = 1'b1;
  bit          m_ovr    = 1'b0;
  bit          chk_en   = 1'b0;
  logic [NB-1:0] sword  = '0;
  int          mk;
  int          dk;
  int          ck;
  bit          m_done;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_cyc = 0; m_e0 = 0; m_active = 1'b0; m_shift = '0; m_result = '0;
      m_int_n = 1'b1; m_ovr = 1'b0;
    end else begin
      m_cyc++;
      mk = m_cyc - m_e0;
      m_done = 1'b0;
      if (m_active) begin
        // bit i is taken at the dsc rise of its period: E0+CC+2*CD*i+CD
        if (mk >= CC && ((mk - CC) % (2 * CD)) == CD && ((mk - CC) / (2 * CD)) < NB)
          m_shift = {m_shift[NB-2:0], bus.sdata};
        if (mk == TOT) begin
          m_done = 1'b1;
          m_active = 1'b0;
        end
      end
      if (m_done) begin
        if (!m_int_n) m_ovr = 1'b1;
        m_int_n  = 1'b0;
        m_result = m_shift;
      end else if (!bus.cs_n && !bus.rd_n) begin
        m_int_n = 1'b1;
        m_ovr   = 1'b0;
      end
      if (!m_active && !m_done && bus.start) begin
        m_active = 1'b1;
        m_e0     = m_cyc;
      end
    end
  end

  // converter model: presents sword MSB first, one bit per dsc period
  initial forever begin
    @(posedge clk);
    #1;
    dk = m_cyc + 1 - m_e0 - CC;
    if (m_active && dk >= 0 && dk < SHIFT_LEN) bus.sdata = sword[NB - 1 - dk / (2 * CD)];
    else bus.sdata = 1'b0;
  end

  // per-cycle comparison of all outputs against the model
  logic [5:0]    exp_v;
  logic [5:0]    act_v;
  logic [NB-1:0] exp_d;
  bit            e_conv, e_take, e_dsc;
  initial forever begin
    @(negedge clk);
    if (chk_en && rst_n) begin
      ck     = m_cyc - m_e0;
      e_conv = m_active && ck < CC;
      e_take = m_active && ck >= CC && ck < CC + SHIFT_LEN;
      e_dsc  = e_take && (((ck - CC) % (2 * CD)) >= CD);
      exp_v  = {e_conv, e_dsc, e_take, m_active, m_int_n, m_ovr};
      act_v  = {bus.conv, bus.dsc, bus.take, bus.busy, bus.int_n, bus.overrun};
      n_tests++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL outputs t=%0t got conv/dsc/take/busy/int_n/ovr=%b expected %b", $time, act_v, exp_v);
      end
      exp_d = (!bus.cs_n && !bus.rd_n) ? m_result : {NB{1'b1}};
      n_tests++;
      if (data_bus !== exp_d) begin
        n_fail++;
        $display("FAIL data_port t=%0t got %h expected %h", $time, data_bus, exp_d);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_read(output logic [NB-1:0] d);
    bus.cs_n = 1'b0;
    bus.rd_n = 1'b0;
    @(negedge clk);
    d = data_bus;
    @(posedge clk);
    #1;
    bus.cs_n = 1'b1;
    bus.rd_n = 1'b1;
  endtask

  // one conversion from IDLE; returns edges from E0 until busy drops
  task automatic run_conv(input logic [NB-1:0] w, input bit pulse_mid, input bit rd_at_done,
                          output int lat, output int nconv, output int ntake, output int ndsc);
    logic pd;
    sword = w; lat = -1; nconv = 0; ntake = 0; ndsc = 0; pd = 1'b0;
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    for (int k = 0; k < TOT + 20; k++) begin
      if (bus.conv) nconv++;
      if (bus.take) ntake++;
      if (bus.dsc && !pd) ndsc++;
      pd = bus.dsc;
      if (k > 0 && !bus.busy) begin
        lat = k;
        break;
      end
      bus.start = pulse_mid && (k == 4 || k == 39);
      if (rd_at_done && k == TOT - 1) begin
        bus.cs_n = 1'b0;
        bus.rd_n = 1'b0;
      end
      step(1);
    end
    bus.start = 1'b0;
    bus.cs_n  = 1'b1;
    bus.rd_n  = 1'b1;
  endtask

  // ---------------- directed sequence ----------------
  int            lat, nc, nt, nd, nr;
  logic [NB-1:0] d;
  logic          prev;

  initial begin
    bus.start = 1'b0; bus.cs_n = 1'b1; bus.rd_n = 1'b1;
    bus_f.start = 1'b0; bus_f.sdata = 1'b0; bus_f.cs_n = 1'b1; bus_f.rd_n = 1'b1;
    rst_n = 1'b0;
    step(3);
    chk("reset_ctrl", {bus.conv, bus.dsc, bus.take, bus.busy}, 4'b0000);
    chk("reset_int_n", bus.int_n, 1'b1);
    chk("reset_overrun", bus.overrun, 1'b0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    step(2);

    // basic conversion 0xA5
    run_conv(8'hA5, 1'b0, 1'b0, lat, nc, nt, nd);
    chk("a5_latency", lat, 81);
    chk("a5_conv_cycles", nc, 16);
    chk("a5_take_cycles", nt, 64);
    chk("a5_dsc_pulses", nd, 8);
    chk("a5_int_low", bus.int_n, 1'b0);
    do_read(d);
    chk("a5_read", d, 8'hA5);
    chk("a5_int_cleared", bus.int_n, 1'b1);

    // port isolation
    bus.cs_n = 1'b1; bus.rd_n = 1'b0; #1;
    chk("iso_cs_high", data_bus, 8'hFF);
    bus.cs_n = 1'b0; bus.rd_n = 1'b1; #1;
    chk("iso_rd_high", data_bus, 8'hFF);
    bus.cs_n = 1'b1; bus.rd_n = 1'b1;
    step(2);

    // start pulses during CONV and SHIFT are ignored
    run_conv(8'h69, 1'b1, 1'b0, lat, nc, nt, nd);
    chk("pulse_latency", lat, 81);
    do_read(d);
    chk("pulse_read", d, 8'h69);
    step(1);

    // start held high: one conversion per IDLE entry
    sword = 8'h96; bus.start = 1'b1; nr = 0; prev = 1'b0;
    for (int i = 0; i < 170; i++) begin
      step(1);
      if (bus.conv && !prev) nr++;
      prev = bus.conv;
    end
    bus.start = 1'b0;
    chk("hold_conv_starts", nr, 3);
    for (int i = 0; i < 200 && bus.busy; i++) step(1);
    chk("hold_finished", bus.busy, 1'b0);
    chk("hold_overrun", bus.overrun, 1'b1);
    do_read(d);
    chk("hold_read", d, 8'h96);
    chk("hold_ovr_cleared", {bus.int_n, bus.overrun}, 2'b10);

    // overrun: 0x3C unread, then 0xC3
    run_conv(8'h3C, 1'b0, 1'b0, lat, nc, nt, nd);
    chk("ovr_first", {bus.int_n, bus.overrun}, 2'b00);
    run_conv(8'hC3, 1'b0, 1'b0, lat, nc, nt, nd);
    chk("ovr_second", {bus.int_n, bus.overrun}, 2'b01);
    do_read(d);
    chk("ovr_read", d, 8'hC3);
    chk("ovr_cleared", {bus.int_n, bus.overrun}, 2'b10);

    // read on the same edge as DONE
    run_conv(8'h5A, 1'b0, 1'b1, lat, nc, nt, nd);
    chk("coinc_flags", {bus.int_n, bus.overrun}, 2'b00);
    do_read(d);
    chk("coinc_read", d, 8'h5A);

    // reset in the middle of SHIFT with a result pending
    run_conv(8'h0F, 1'b0, 1'b0, lat, nc, nt, nd);
    sword = 8'h33; bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    step(55);
    chk("pre_rst_shift", {bus.take, bus.dsc, bus.int_n}, 3'b110);
    rst_n = 1'b0;
    #1;
    chk("async_rst_ctrl", {bus.conv, bus.dsc, bus.take, bus.busy}, 4'b0000);
    chk("async_rst_flags", {bus.int_n, bus.overrun}, 2'b10);
    step(2);
    rst_n = 1'b1;
    step(2);
    run_conv(8'hFF, 1'b0, 1'b0, lat, nc, nt, nd);
    chk("post_rst_latency", lat, 81);
    chk("post_rst_dsc_pulses", nd, 8);
    do_read(d);
    chk("post_rst_read", d, 8'hFF);

    // fast variant: CLK_DIV=1, CONV_CYCLES=1, only the LSB set
    bus_f.start = 1'b1;
    step(1);
    bus_f.start = 1'b0;
    for (int k = 0; k < 19; k++) begin
      bus_f.sdata = (k >= 15);
      @(negedge clk);
      if (k == 0) chk("fast_conv_on", {bus_f.conv, bus_f.take}, 2'b10);
      if (k == 1) chk("fast_conv_off", {bus_f.conv, bus_f.take}, 2'b01);
      chk("fast_dsc", bus_f.dsc, (k >= 1 && k <= 16 && (k % 2) == 0));
      if (k == 17) chk("fast_int_e17", bus_f.int_n, 1'b1);
      if (k == 18) chk("fast_int_e18", bus_f.int_n, 1'b0);
      if (k < 18) step(1);
    end
    bus_f.cs_n = 1'b0; bus_f.rd_n = 1'b0;
    #1;
    chk("fast_read", data_f, 8'h01);
    step(1);
    bus_f.cs_n = 1'b1; bus_f.rd_n = 1'b1;
    chk("fast_int_cleared", bus_f.int_n, 1'b1);

    step(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_adc_ctrl.md
Name: serial_adc_ctrl

Overview:
- Sequencer for an external 8-bit serial-output A/D converter and its serial-to-parallel capture path.
- On a CPU start command it pulses the converter's convert input and waits for conversion.
- It then generates the serial clock (dsc) and shift window (take), assembles the bits into a parallel word, and interrupts the CPU.
- The CPU reads the result through an address-decoded, tri-stated data port; the read clears the interrupt.

Parameters:
NBITS, 8, serial bits per conversion, MSB first
CLK_DIV, 4, clk cycles per dsc half-period (>=1)
CONV_CYCLES, 16, clk cycles conv is held high (converter busy time, >=1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  CPU start request, sampled high for one or more cycles
sdata  input  1  serial data from converter (D_out)
cs_n  input  1  active-low address decode for the result port
rd_n  input  1  active-low CPU read strobe
conv  output  1  convert command to converter
dsc  output  1  serial shift clock to converter
take  output  1  high while serial bits are being shifted
data  output  NBITS  result port, driven only while cs_n=0 and rd_n=0, else high-Z
int_n  output  1  active-low interrupt, result ready
busy  output  1  conversion/shift in progress
overrun  output  1  sticky, a result was overwritten before being read

Behaviour:
- Reset (async, rst_n=0) forces the following immediately, from any state:
  - State IDLE; conv=0, dsc=0, take=0, busy=0.
  - int_n=1, overrun=0, result register=0, shift register=0, counters=0.
- FSM states: IDLE, CONV, SHIFT, DONE.
- IDLE:
  - If start=1 at an edge (call it E0), go to CONV; busy=1 from E0.
  - start is ignored in every state other than IDLE (no queuing).
- CONV:
  - conv=1 for exactly CONV_CYCLES cycles after E0.
  - Then conv=0 and the FSM enters SHIFT at edge E0+CONV_CYCLES.
- SHIFT:
  - take=1 for exactly 2*CLK_DIV*NBITS cycles.
  - A phase counter ph runs 0..2*CLK_DIV-1 per bit; dsc=1 when ph>=CLK_DIV, else 0. dsc is registered and glitch-free.
  - sdata is captured at the edge where dsc goes 0->1. The shift register shifts left by 1 and sdata enters bit 0, so the first bit lands in the MSB.
  - A bit counter counts 0..NBITS-1. After the last bit's high phase, go to DONE with take=0 and dsc=0.
- DONE (one cycle):
  - Shift register is copied to the result register; int_n=0; busy=0; return to IDLE.
  - If int_n was already 0 (previous result unread), set overrun=1. The new result still replaces the old one.
- Default timing: result valid and int_n low at edge E0+CONV_CYCLES+2*CLK_DIV*NBITS+1, i.e. E0+81 with defaults.
- Read:
  - data = result register combinationally while cs_n=0 and rd_n=0, otherwise all bits Z.
  - A read is any clk edge sampling cs_n=0 and rd_n=0. It sets int_n=1 and clears overrun at that edge.
  - If a read and DONE fall on the same edge, DONE wins: int_n=0, and overrun=1 only if a result was pending before this edge.
- The result register is unchanged by reads and holds until the next DONE.
- cs_n/rd_n activity during CONV/SHIFT returns the previous result and does not disturb the sequence.
- New start is accepted on the first IDLE cycle after DONE (back-to-back conversions allowed).

Test Plan:
- Reset, then start pulse at E0, sdata driven MSB-first 1,0,1,0,0,1,0,1 sampled at dsc rises:
  - conv high for 16 cycles; take high for 64 cycles; 8 dsc pulses, each 4 low/4 high.
  - int_n low at E0+81; read with cs_n=0, rd_n=0 returns 0xA5.
  - int_n returns to 1 on the edge after the read.
- Port isolation: cs_n=1,rd_n=0 and cs_n=0,rd_n=1 -> data all Z.
- Busy rejection: start=1 held continuously -> exactly one conversion per IDLE entry; start pulses during CONV/SHIFT have no effect; busy timing as specified.
- Overrun: conversion 0x3C, no read, second conversion 0xC3:
  - overrun=1 at the second DONE; read returns 0xC3.
  - The read clears int_n and overrun.
- Read coinciding with DONE (int_n previously 1): int_n=0, overrun=0, data reads the new value on the next read.
- Reset mid-SHIFT (after bit 4):
  - take, dsc, conv go to 0 and int_n to 1 asynchronously.
  - A new start gives a clean full-length 8-bit sequence with the correct result (0xFF from constant sdata=1).
- Parameter variant: CLK_DIV=1, CONV_CYCLES=1, sdata=0 except the LSB=1:
  - dsc toggles every cycle; int_n low at E0+18; data=0x01.
